// File: rtl/sha_feed_pkg.sv
// Shared definitions for the SHA-256 message padding front end.
// Contents: FSM state encoding, block geometry constants, and a helper that
// picks one byte of the big-endian 64-bit message bit length.
package sha_feed_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_PAD,
    S_LEN,
    S_ISSUE,
    S_WAIT
  } state_t;

  localparam int         BLK_BYTES = 64;
  localparam int         LEN_OFF   = 56;
  localparam logic [7:0] PAD_BYTE  = 8'h80;
  localparam int         SHA_BLK_W = 512;

  // Byte of the length field that belongs at block position idx (56..63),
  // most significant byte first.
  function automatic logic [7:0] len_byte(input logic [63:0] bits,
                                          input logic [5:0]  idx);
    logic [2:0] k;
    k = idx[2:0];
    return bits[63 - 8*int'(k) -: 8];
  endfunction

endpackage

// File: rtl/sha_feed_buf.sv
// sha_blk_buf: 64-byte block register with indexed byte write.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clr         synchronous clear of every byte (wins over wr_en)
//   wr_en       write wr_data into byte wr_idx
//   wr_idx      byte index, 0 = first message byte of the block
//   wr_data     byte to write
//   data        flat read-out, byte 0 at [511:504]
module sha_blk_buf
  import sha_feed_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 wr_en,
  input  logic [5:0]           wr_idx,
  input  logic [7:0]           wr_data,
  output logic [SHA_BLK_W-1:0] data
);

  logic [7:0] mem [BLK_BYTES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BLK_BYTES; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < BLK_BYTES; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  for (genvar g = 0; g < BLK_BYTES; g++) begin : g_out
    assign data[SHA_BLK_W-1-8*g -: 8] = mem[g];
  end

endmodule

// File: rtl/sha_pad_feeder.sv
// sha_pad_feeder: accepts a message byte stream, builds 512-bit blocks with
// SHA-256 padding (0x80, zero fill, 64-bit big-endian bit length) and hands
// each block to the hash core with a start/done handshake.
// Optional feature: define SHA_FEED_LENCHK_EN to flag byte-count overflow on
// err_len and drop the message; otherwise the count wraps silently.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_data/in_last    byte stream in, in_last marks final byte
//   in_ready                    byte accepted when in_valid && in_ready
//   blk_data                    block to core, byte 0 at [511:504]
//   blk_start                   one-cycle pulse, block valid, core starts
//   blk_first/blk_last          block position flags, valid with blk_start
//   core_done                   core has consumed the block
//   busy                        not idle
//   msg_done                    pulse after the final block completes
//   err_len                     pulse on length overflow (feature build only)
//
// state   | meaning
// IDLE    | waiting for the first byte of a message
// FILL    | collecting message bytes into the block
// PAD     | writing 0x80 / zero fill, one byte per cycle
// LEN     | writing the 8 length bytes at 56..63
// ISSUE   | blk_start pulse
// WAIT    | block owned by the core until core_done
module sha_pad_feeder
  import sha_feed_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [SHA_BLK_W-1:0] blk_data,
  output logic                 blk_start,
  output logic                 blk_first,
  output logic                 blk_last,
  input  logic                 core_done,
  output logic                 busy,
  output logic                 msg_done,
  output logic                 err_len
);

  state_t           state, state_nx;
  logic [5:0]       idx, idx_nx;
  logic [LEN_W-1:0] byte_cnt, byte_cnt_nx;
  logic             first_flag, first_nx;
  logic             last_flag, last_nx;
  logic             pad_pend, pad_pend_nx;
  logic             pad_sent, pad_sent_nx;
  logic             armed;
  logic             msg_done_nx;
  logic             buf_clr, buf_wr;
  logic [7:0]       buf_byte;
  logic             accept;
  logic             len_ovf;
  logic [63:0]      len_bits;

  // in_ready stays low until the first clock after reset release.
  assign in_ready  = armed && (state == S_IDLE || state == S_FILL);
  assign accept    = in_valid && in_ready;
  assign busy      = (state != S_IDLE);
  assign blk_start = (state == S_ISSUE);
  assign blk_first = blk_start && first_flag;
  assign blk_last  = blk_start && last_flag;
  assign len_bits  = 64'(byte_cnt) << 3;

`ifdef SHA_FEED_LENCHK_EN
  logic err_q;
  assign len_ovf = (state == S_FILL) && accept && !in_last && (byte_cnt == '1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= len_ovf;
  end
  assign err_len = err_q;
`else
  assign len_ovf = 1'b0;
  assign err_len = 1'b0;
`endif

  sha_blk_buf u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (buf_clr),
    .wr_en   (buf_wr),
    .wr_idx  (idx),
    .wr_data (buf_byte),
    .data    (blk_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      byte_cnt   <= '0;
      first_flag <= 1'b0;
      last_flag  <= 1'b0;
      pad_pend   <= 1'b0;
      pad_sent   <= 1'b0;
      armed      <= 1'b0;
      msg_done   <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      byte_cnt   <= byte_cnt_nx;
      first_flag <= first_nx;
      last_flag  <= last_nx;
      pad_pend   <= pad_pend_nx;
      pad_sent   <= pad_sent_nx;
      armed      <= 1'b1;
      msg_done   <= msg_done_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    byte_cnt_nx = byte_cnt;
    first_nx    = first_flag;
    last_nx     = last_flag;
    pad_pend_nx = pad_pend;
    pad_sent_nx = pad_sent;
    msg_done_nx = 1'b0;
    buf_clr     = 1'b0;
    buf_wr      = 1'b0;
    buf_byte    = in_data;

    case (state)
      S_IDLE: begin
        if (accept) begin
          buf_wr      = 1'b1;
          idx_nx      = 6'd1;
          byte_cnt_nx = LEN_W'(1);
          first_nx    = 1'b1;
          last_nx     = 1'b0;
          pad_pend_nx = 1'b0;
          pad_sent_nx = 1'b0;
          state_nx    = in_last ? S_PAD : S_FILL;
        end
      end

      S_FILL: begin
        if (accept) begin
          if (len_ovf) begin
            buf_clr     = 1'b1;
            idx_nx      = '0;
            byte_cnt_nx = '0;
            first_nx    = 1'b0;
            state_nx    = S_IDLE;
          end else begin
            buf_wr      = 1'b1;
            idx_nx      = idx + 6'd1;
            byte_cnt_nx = byte_cnt + LEN_W'(1);
            if (idx == 6'd63) begin
              state_nx    = S_ISSUE;
              pad_pend_nx = in_last;
            end else if (in_last) begin
              state_nx = S_PAD;
            end
          end
        end
      end

      S_PAD: begin
        buf_wr      = 1'b1;
        buf_byte    = pad_sent ? 8'h00 : PAD_BYTE;
        pad_sent_nx = 1'b1;
        idx_nx      = idx + 6'd1;
        if (idx == 6'(LEN_OFF - 1)) begin
          state_nx = S_LEN;
        end else if (idx == 6'd63) begin
          // No room for the length field: it goes into an extra block.
          state_nx    = S_ISSUE;
          pad_pend_nx = 1'b1;
        end
      end

      S_LEN: begin
        buf_wr   = 1'b1;
        buf_byte = len_byte(len_bits, idx);
        idx_nx   = idx + 6'd1;
        if (idx == 6'd63) begin
          state_nx = S_ISSUE;
          last_nx  = 1'b1;
        end
      end

      S_ISSUE: begin
        first_nx = 1'b0;
        state_nx = S_WAIT;
      end

      S_WAIT: begin
        if (core_done) begin
          idx_nx = '0;
          if (last_flag) begin
            state_nx    = S_IDLE;
            msg_done_nx = 1'b1;
            buf_clr     = 1'b1;
            last_nx     = 1'b0;
            pad_sent_nx = 1'b0;
            byte_cnt_nx = '0;
          end else if (pad_pend) begin
            state_nx    = S_PAD;
            pad_pend_nx = 1'b0;
          end else begin
            state_nx = S_FILL;
          end
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sha_pad_feeder.sv
module tb_sha_pad_feeder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic [511:0] blk_data;
  logic         blk_start, blk_first, blk_last;
  logic         core_done = 1'b0;
  logic         busy, msg_done, err_len;

  logic         v4 = 1'b0;
  logic [7:0]   d4 = 8'h00;
  logic         l4 = 1'b0;
  logic         c4_done = 1'b0;
  logic         rdy4, st4, f4, la4, busy4, md4, err4;
  logic [511:0] data4;

  always #5 clk = ~clk;

  sha_pad_feeder #(.LEN_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .blk_data(blk_data),
    .blk_start(blk_start), .blk_first(blk_first), .blk_last(blk_last),
    .core_done(core_done), .busy(busy), .msg_done(msg_done), .err_len(err_len)
  );

  sha_pad_feeder #(.LEN_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_data(d4),
    .in_last(l4), .in_ready(rdy4), .blk_data(data4),
    .blk_start(st4), .blk_first(f4), .blk_last(la4),
    .core_done(c4_done), .busy(busy4), .msg_done(md4), .err_len(err4)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int md_cnt = 0, err4_cnt = 0, st4_cnt = 0;
  always @(negedge clk) begin
    if (msg_done === 1'b1) md_cnt++;
    if (err4 === 1'b1) err4_cnt++;
    if (st4 === 1'b1) st4_cnt++;
  end

  // Core model: captures each issued block and answers after core_delay cycles.
  logic [511:0] q_data[$];
  bit           q_first[$], q_last[$], q_md[$];
  int           q_cyc[$];
  int           core_delay = 2;
  bit           core_hold = 0;
  bit           wait_bad = 0;
  logic [511:0] mon_d;

  initial begin
    forever begin
      @(negedge clk);
      if (blk_start === 1'b1) begin
        mon_d = blk_data;
        q_data.push_back(mon_d);
        q_first.push_back(blk_first);
        q_last.push_back(blk_last);
        q_cyc.push_back(cyc);
        for (int i = 0; i < core_delay; i++) begin
          @(negedge clk);
          if (rst_n && (in_ready !== 1'b0 || blk_data !== mon_d)) wait_bad = 1;
        end
        while (core_hold) @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        q_md.push_back(msg_done);
        core_done = 1'b0;
      end
    end
  end

  bit drv_to = 0;
  int last_acc_cyc = 0;

  function automatic logic [7:0] bval(input int kind, input int i);
    case (kind)
      0:       return 8'(8'h61 + i);
      1:       return 8'h00;
      2:       return 8'(i);
      default: return 8'(i * 7 + 3);
    endcase
  endfunction

  function automatic logic [511:0] exp_blk(input int kind, input int start, input int n,
                                           input bit pad80, input bit has_len,
                                           input logic [63:0] lenbits);
    logic [511:0] r;
    logic [7:0]   b;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < n)                 b = bval(kind, start + i);
      else if (i == n && pad80)  b = 8'h80;
      else                       b = 8'h00;
      r[511 - 8*i -: 8] = b;
    end
    if (has_len) r[63:0] = lenbits;
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic send_byte(input logic [7:0] d, input logic last);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (in_ready !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) drv_to = 1;
    @(posedge clk);
    @(negedge clk);
    if (last) last_acc_cyc = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_msg(input int n, input int kind);
    for (int i = 0; i < n; i++) send_byte(bval(kind, i), (i == n - 1));
  endtask

  task automatic wait_msg(input int target, input string tag);
    int t;
    t = 0;
    while (md_cnt < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, (md_cnt >= target), 1'b1);
  endtask

  task automatic clear_q();
    q_data.delete(); q_first.delete(); q_last.delete(); q_md.delete(); q_cyc.delete();
  endtask

  task automatic check_abc(input string tag);
    chk({tag, "_nblk"}, q_data.size(), 1);
    chk({tag, "_data"}, q_data[0], {32'h61626380, 416'h0, 64'h18});
    chk({tag, "_first"}, q_first[0], 1'b1);
    chk({tag, "_last"}, q_last[0], 1'b1);
    chk({tag, "_md_next"}, q_md[0], 1'b1);
    chk({tag, "_lat"}, q_cyc[0] - last_acc_cyc, 61);
  endtask

  int md0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_blk_data", blk_data, '0);
    chk("rst_ctrl", {blk_start, blk_first, blk_last, busy, msg_done, err_len}, 6'b0);
    rst_n = 1'b1;
    #1 chk("rst_rel_ready0", in_ready, 1'b0);
    @(negedge clk);
    chk("rst_rel_ready1", in_ready, 1'b1);

    // "abc"
    clear_q();
    send_msg(3, 0);
    wait_msg(1, "abc_done");
    repeat (3) @(negedge clk);
    check_abc("abc");
    chk("abc_md_once", md_cnt, 1);
    chk("abc_idle", busy, 1'b0);

    // 56 zero bytes: length spills into a second block
    clear_q();
    send_msg(56, 1);
    wait_msg(2, "z56_done");
    chk("z56_nblk", q_data.size(), 2);
    chk("z56_b1", q_data[0], {448'h0, 8'h80, 56'h0});
    chk("z56_b2", q_data[1], {448'h0, 64'h1C0});
    chk("z56_flags1", {q_first[0], q_last[0]}, 2'b10);
    chk("z56_flags2", {q_first[1], q_last[1]}, 2'b01);

    // 64 bytes: raw block then pure padding block
    clear_q();
    send_msg(64, 2);
    wait_msg(3, "b64_done");
    chk("b64_nblk", q_data.size(), 2);
    chk("b64_b1", q_data[0], exp_blk(2, 0, 64, 0, 0, 64'h0));
    chk("b64_b2", q_data[1], {8'h80, 440'h0, 64'h200});
    chk("b64_flags", {q_first[0], q_last[0], q_first[1], q_last[1]}, 4'b1001);

    // 130 bytes, slow core
    clear_q();
    wait_bad = 0;
    core_delay = 20;
    send_msg(130, 3);
    wait_msg(4, "b130_done");
    chk("b130_wait_hold", wait_bad, 1'b0);
    chk("b130_nblk", q_data.size(), 3);
    chk("b130_b1", q_data[0], exp_blk(3, 0, 64, 0, 0, 64'h0));
    chk("b130_b2", q_data[1], exp_blk(3, 64, 64, 0, 0, 64'h0));
    chk("b130_b3", q_data[2], exp_blk(3, 128, 2, 1, 1, 64'h410));
    chk("b130_first", {q_first[0], q_first[1], q_first[2]}, 3'b100);
    chk("b130_last", {q_last[0], q_last[1], q_last[2]}, 3'b001);
    core_delay = 2;

    // Reset during WAIT of block 1
    clear_q();
    core_hold = 1;
    md0 = md_cnt;
    send_msg(3, 0);
    for (int t = 0; t < 200 && q_data.size() == 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("rw_in_wait", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rw_blk_data", blk_data, '0);
    chk("rw_ctrl", {in_ready, blk_start, blk_first, blk_last, busy, msg_done, err_len}, 7'b0);
    @(negedge clk);
    rst_n = 1'b1;
    core_hold = 0;
    repeat (6) @(negedge clk);
    chk("rw_no_md", md_cnt, md0);
    chk("rw_idle", busy, 1'b0);
    clear_q();
    send_msg(3, 0);
    wait_msg(md0 + 1, "rw_abc_done");
    check_abc("rw_abc");

    // Narrow counter: 16 bytes without in_last
    for (int i = 0; i < 16; i++) begin
      v4 = 1'b1;
      d4 = 8'(i);
      chk("len_ready", rdy4, 1'b1);
      @(posedge clk);
      @(negedge clk);
    end
    v4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("len_no_start", st4_cnt, 0);
`ifdef SHA_FEED_LENCHK_EN
    chk("len_err_pulse", err4_cnt, 1);
    chk("len_idle", busy4, 1'b0);
`else
    chk("len_err_zero", err4_cnt, 0);
    chk("len_busy", busy4, 1'b1);
`endif

    chk("drv_timeout", drv_to, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
